muldiv_seq: RTL

- Iterative multiply/divide sequencer. Executes the `mult`/`div` operations flagged by the instruction decoder.
- Sits beside the ALU in the execute stage. It captures rs1/rs2 operands and the destination register on a start pulse, runs a fixed-length shift-add or restoring-divide loop, and returns the result with a one-cycle done pulse.
- Holds the pipeline stall while it is busy. Can be aborted by the execute stage on trap or flush.

---
 rtl/muldiv_seq_pkg.sv | 29 ++
 rtl/muldiv_seq_if.sv | 25 ++
 rtl/muldiv_seq_step.sv | 38 +++
 rtl/muldiv_seq.sv | 114 +++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// FSM encoding, divide-by-zero result and the ALU opcode set.
package muldiv_seq_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // Quotient returned for x/0; callers slice the low RV bits.
  localparam logic [31:0] MD_DIV0_RESULT = 32'hFFFF_FFFF;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_MUL  = 4'd10,
    OP_DIVU = 4'd11
  } alu_op_e;

endpackage

// File: rtl/muldiv_seq_if.sv
// Execute-stage <-> multiply/divide sequencer handshake bundle.
interface muldiv_seq_if #(
  parameter int RV = 32
);
  logic          start;
  logic          is_div;
  logic [RV-1:0] a;
  logic [RV-1:0] b;
  logic [3:0]    rd_in;
  logic          kill;
  logic          busy;
  logic          done;
  logic [RV-1:0] result;
  logic [3:0]    rd_out;

  modport master (
    output start, is_div, a, b, rd_in, kill,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, is_div, a, b, rd_in, kill,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/muldiv_seq_step.sv
// One iteration of the sequencer datapath: shift-add for multiply,
// shift/compare/subtract (restoring) for unsigned divide.
module muldiv_step #(
  parameter int RV = 32
) (
  input  logic          is_div,
  input  logic [RV-1:0] op_a,
  input  logic [RV-1:0] op_b,
  input  logic [RV-1:0] acc,
  input  logic [RV-1:0] rem,
  output logic [RV-1:0] op_a_nx,
  output logic [RV-1:0] op_b_nx,
  output logic [RV-1:0] acc_nx,
  output logic [RV-1:0] rem_nx
);

  logic [RV:0] trial;
  logic [RV:0] diff;
  logic        ge;

  always_comb begin
    // Shifted remainder needs RV+1 bits: it can reach 2*divisor-1.
    trial   = {rem, op_a[RV-1]};
    diff    = trial - {1'b0, op_b};
    ge      = ~diff[RV];
    op_a_nx = op_a << 1;
    if (is_div) begin
      op_b_nx = op_b;
      rem_nx  = ge ? diff[RV-1:0] : trial[RV-1:0];
      acc_nx  = {acc[RV-2:0], ge};
    end else begin
      op_b_nx = op_b >> 1;
      rem_nx  = rem;
      acc_nx  = op_b[0] ? (acc + op_a) : acc;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer: captures operands on start, runs RV
// iterations, returns the low product or unsigned quotient with a done pulse.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int RV = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  muldiv_seq_if.slave io
);

  localparam int CW = $clog2(RV) + 1;

  md_state_e     state;
  md_state_e     state_nx;
  logic [CW-1:0] cnt;
  logic [RV-1:0] op_a;
  logic [RV-1:0] op_b;
  logic [RV-1:0] acc;
  logic [RV-1:0] rem;
  logic [RV-1:0] result_q;
  logic [3:0]    rd_q;
  logic [3:0]    rd_out_q;
  logic          is_div_q;

  logic [RV-1:0] op_a_nx;
  logic [RV-1:0] op_b_nx;
  logic [RV-1:0] acc_nx;
  logic [RV-1:0] rem_nx;

  logic launch;
  logic div0;
  logic done;

  assign launch = (state == MD_IDLE) && io.start && !io.kill;
  assign div0   = io.is_div && (io.b == '0);

  muldiv_step #(.RV(RV)) u_step (
    .is_div  (is_div_q),
    .op_a    (op_a),
    .op_b    (op_b),
    .acc     (acc),
    .rem     (rem),
    .op_a_nx (op_a_nx),
    .op_b_nx (op_b_nx),
    .acc_nx  (acc_nx),
    .rem_nx  (rem_nx)
  );

  always_comb begin
    state_nx = state;
    case (state)
      MD_IDLE: if (launch) state_nx = div0 ? MD_DONE : MD_RUN;
      MD_RUN: begin
        if (io.kill)              state_nx = MD_IDLE;
        else if (cnt == CW'(1))   state_nx = MD_DONE;
      end
      MD_DONE: state_nx = MD_IDLE;
      default: state_nx = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= MD_IDLE;
    else          state <= state_nx;
  end

  // Counter, accumulator/remainder and the held result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      acc      <= '0;
      rem      <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      if (launch) begin
        cnt <= CW'(RV);
        acc <= div0 ? MD_DIV0_RESULT[RV-1:0] : '0;
        rem <= '0;
      end else if (state == MD_RUN) begin
        cnt <= cnt - CW'(1);
        acc <= acc_nx;
        rem <= rem_nx;
      end
      if (done) begin
        result_q <= acc;
        rd_out_q <= rd_q;
      end
    end
  end

  // Operand shift registers carry no reset; they are loaded on every launch.
  always_ff @(posedge clk) begin
    if (launch) begin
      op_a     <= io.a;
      op_b     <= io.b;
      rd_q     <= io.rd_in;
      is_div_q <= io.is_div;
    end else if (state == MD_RUN) begin
      op_a <= op_a_nx;
      op_b <= op_b_nx;
    end
  end

  // A kill in the DONE cycle suppresses done and keeps the old result visible.
  assign done      = (state == MD_DONE) && !io.kill;
  assign io.done   = done;
  assign io.busy   = (state != MD_IDLE);
  assign io.result = done ? acc  : result_q;
  assign io.rd_out = done ? rd_q : rd_out_q;

endmodule
